// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - handshaked RV32I data memory with sub-word access, wait states and fault reporting
module data_mem_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} stateT;

    stateT state, nextState;

    logic              weQ;
    logic [2:0]        funct3Q;
    logic [ADDR_W-1:0] addrQ;
    logic [31:0]       wdataQ;
    logic [3:0]        waitCnt;
    logic [31:0]       rspRdataQ;
    logic              rspErrQ;

    logic [31:0] mem [DEPTH];

    logic              curWe;
    logic [2:0]        curFunct3;
    logic [ADDR_W-1:0] curAddr;
    logic [31:0]       curWdata;
    logic [IDX_W-1:0]  curIdx;
    logic [1:0]        lane;
    logic              accept;
    logic              commit;
    logic              fault;
    logic [3:0]        byteEn;
    logic [31:0]       wdataAligned;
    logic [31:0]       readWord;
    logic [7:0]        laneByte;
    logic [15:0]       laneHalf;
    logic [31:0]       loadVal;

    assign accept = req_valid && (state == ST_IDLE);

    // With no wait states the commit happens on the accept edge itself, so it
    // must see the live request rather than the not-yet-latched copy.
    assign commit = (accept && (WAIT_CYCLES == 0)) || ((state == ST_WAIT) && (waitCnt == 4'd0));

    always_comb begin
        curWe     = weQ;
        curFunct3 = funct3Q;
        curAddr   = addrQ;
        curWdata  = wdataQ;
        if (state == ST_IDLE) begin
            curWe     = req_we;
            curFunct3 = req_funct3;
            curAddr   = req_addr;
            curWdata  = req_wdata;
        end
    end

    assign curIdx = curAddr[IDX_W+1:2];
    assign lane   = curAddr[1:0];

    always_comb begin
        fault = 1'b0;
        if ((curFunct3 == 3'd3) || (curFunct3 == 3'd6) || (curFunct3 == 3'd7))
            fault = 1'b1;
        if (curWe && curFunct3[2])
            fault = 1'b1;
        if ((curFunct3[1:0] == 2'd1) && curAddr[0])
            fault = 1'b1;
        if ((curFunct3 == 3'd2) && (curAddr[1:0] != 2'd0))
            fault = 1'b1;
        if ((curAddr >> (IDX_W + 2)) != '0)
            fault = 1'b1;
    end

    always_comb begin
        byteEn       = 4'b0000;
        wdataAligned = curWdata;
        case (curFunct3[1:0])
            2'd0: begin
                byteEn       = 4'b0001 << lane;
                wdataAligned = {4{curWdata[7:0]}};
            end
            2'd1: begin
                byteEn       = lane[1] ? 4'b1100 : 4'b0011;
                wdataAligned = {2{curWdata[15:0]}};
            end
            2'd2: byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase
    end

    assign readWord = mem[curIdx];
    assign laneByte = readWord[{lane, 3'b000} +: 8];
    assign laneHalf = lane[1] ? readWord[31:16] : readWord[15:0];

    always_comb begin
        case (curFunct3)
            3'd0:    loadVal = {{24{laneByte[7]}}, laneByte};
            3'd1:    loadVal = {{16{laneHalf[15]}}, laneHalf};
            3'd2:    loadVal = readWord;
            3'd4:    loadVal = {24'd0, laneByte};
            3'd5:    loadVal = {16'd0, laneHalf};
            default: loadVal = 32'd0;
        endcase
    end

    // The array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (commit && curWe && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i])
                    mem[curIdx][i*8 +: 8] <= wdataAligned[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: if (req_valid) nextState = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (waitCnt == 4'd0) nextState = ST_RESP;
            ST_RESP: if (rsp_ready) nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weQ       <= 1'b0;
            funct3Q   <= 3'd0;
            addrQ     <= '0;
            wdataQ    <= 32'd0;
            waitCnt   <= 4'd0;
            rspRdataQ <= 32'd0;
            rspErrQ   <= 1'b0;
        end else begin
            if (accept) begin
                weQ     <= req_we;
                funct3Q <= req_funct3;
                addrQ   <= req_addr;
                wdataQ  <= req_wdata;
                waitCnt <= WAIT_INIT;
            end else if ((state == ST_WAIT) && (waitCnt != 4'd0)) begin
                waitCnt <= waitCnt - 4'd1;
            end

            if (commit) begin
                rspRdataQ <= (fault || curWe) ? 32'd0 : loadVal;
                rspErrQ   <= fault;
            end else if ((state == ST_RESP) && rsp_ready) begin
                rspRdataQ <= 32'd0;
                rspErrQ   <= 1'b0;
            end
        end
    end

    assign rsp_rdata = rspRdataQ;
    assign rsp_err   = rspErrQ;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl (zero and three wait-state instances)
module tb_data_mem_ctrl;

    logic        clk;
    logic        rstN      [2];
    logic        reqValid  [2];
    logic        reqReady  [2];
    logic        reqWe     [2];
    logic [2:0]  reqFunct3 [2];
    logic [31:0] reqAddr   [2];
    logic [31:0] reqWdata  [2];
    logic        rspValid  [2];
    logic        rspReady  [2];
    logic [31:0] rspRdata  [2];
    logic        rspErr    [2];
    logic        busy      [2];

    int tests;
    int fails;

    data_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
        .clk(clk), .rst_n(rstN[0]),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
        .req_funct3(reqFunct3[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata[0]),
        .rsp_err(rspErr[0]), .busy(busy[0])
    );

    data_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(3), .ADDR_W(32)) dut3 (
        .clk(clk), .rst_n(rstN[1]),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
        .req_funct3(reqFunct3[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata[1]),
        .rsp_err(rspErr[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete transaction with rsp_ready high; lat counts cycles from accept edge to rsp_valid.
    task automatic access(input int d, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        reqValid[d]  = 1'b1;
        reqWe[d]     = we;
        reqFunct3[d] = f3;
        reqAddr[d]   = addr;
        reqWdata[d]  = wd;
        n = 0;
        while (!reqReady[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 reqValid[d] = 1'b0;
        lat = -1;
        rd  = 32'hxxxxxxxx;
        er  = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rspValid[d]) begin
                lat = i;
                rd  = rspRdata[d];
                er  = rspErr[d];
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if ({reqReady[d], rspValid[d], rspErr[d], busy[d], rspRdata[d]} !== {4'b1000, 32'd0}) begin
                fails++;
                $display("FAIL reset_state dut%0d: got rdy=%b vld=%b err=%b busy=%b rdata=%h, expected rdy=1 vld=0 err=0 busy=0 rdata=0",
                         d, reqReady[d], rspValid[d], rspErr[d], busy[d], rspRdata[d]);
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic er;
        int lat;
        access(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat);
        tests++;
        if ({lat, er, rd} !== {32'd1, 1'b0, 32'd0}) begin
            fails++;
            $display("FAIL sw_0x10: got lat=%0d err=%b rdata=%h, expected lat=1 err=0 rdata=00000000", lat, er, rd);
        end
        access(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        tests++;
        if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL lw_0x10: got err=%b rdata=%h, expected err=0 rdata=deadbeef", er, rd);
        end
    endtask

    task automatic test_subword();
        logic [31:0] rd;
        logic er;
        int lat;
        logic [2:0]  f3Tab  [5] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] adTab  [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] expTab [5] = '{32'hA5ADBEEF, 32'hFFFFFFA5, 32'h000000A5, 32'hFFFFA5AD, 32'h0000BEEF};
        access(0, 1'b1, 3'd0, 32'h13, 32'h000000A5, rd, er, lat);
        tests++;
        if ({er, rd} !== {1'b0, 32'd0}) begin
            fails++;
            $display("FAIL sb_0x13: got err=%b rdata=%h, expected err=0 rdata=00000000", er, rd);
        end
        for (int i = 0; i < 5; i++) begin
            access(0, 1'b0, f3Tab[i], adTab[i], 32'h0, rd, er, lat);
            tests++;
            if ({er, rd} !== {1'b0, expTab[i]}) begin
                fails++;
                $display("FAIL subword_load f3=%0d addr=%h: got err=%b rdata=%h, expected err=0 rdata=%h",
                         f3Tab[i], adTab[i], er, rd, expTab[i]);
            end
        end
        // SH into the upper half of a fresh word, then read it back whole.
        access(0, 1'b1, 3'd2, 32'h14, 32'h11223344, rd, er, lat);
        access(0, 1'b1, 3'd1, 32'h16, 32'h0000CAFE, rd, er, lat);
        access(0, 1'b0, 3'd2, 32'h14, 32'h0, rd, er, lat);
        tests++;
        if ({er, rd} !== {1'b0, 32'hCAFE3344}) begin
            fails++;
            $display("FAIL sh_0x16: got err=%b rdata=%h, expected err=0 rdata=cafe3344", er, rd);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        logic er;
        int lat;
        logic        weTab [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3Tab [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd2};
        logic [31:0] adTab [6] = '{32'h11, 32'h12, 32'h10, 32'h10, 32'h1000, 32'h1010};
        logic [31:0] wdTab [6] = '{32'h0, 32'h11111111, 32'h22222222, 32'h00000033, 32'h0, 32'h44444444};
        for (int i = 0; i < 6; i++) begin
            access(0, weTab[i], f3Tab[i], adTab[i], wdTab[i], rd, er, lat);
            tests++;
            if ({er, rd} !== {1'b1, 32'd0}) begin
                fails++;
                $display("FAIL fault%0d we=%b f3=%0d addr=%h: got err=%b rdata=%h, expected err=1 rdata=00000000",
                         i, weTab[i], f3Tab[i], adTab[i], er, rd);
            end
            access(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
            tests++;
            if ({er, rd} !== {1'b0, 32'hA5ADBEEF}) begin
                fails++;
                $display("FAIL fault%0d_mem_unchanged: got err=%b rdata=%h, expected err=0 rdata=a5adbeef", i, er, rd);
            end
        end
    endtask

    task automatic test_wait_latency();
        logic [31:0] rd;
        logic er;
        int lat;
        access(1, 1'b1, 3'd2, 32'h20, 32'h00000000, rd, er, lat);
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL wait3_store_latency: got %0d, expected 4", lat);
        end
        @(negedge clk);
        reqValid[1]  = 1'b1;
        reqWe[1]     = 1'b0;
        reqFunct3[1] = 3'd2;
        reqAddr[1]   = 32'h24;
        tests++;
        if (reqReady[1] !== 1'b1) begin
            fails++;
            $display("FAIL wait3_ready_at_accept: got %b, expected 1", reqReady[1]);
        end
        @(posedge clk);
        #1 reqValid[1] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            tests++;
            if ({reqReady[1], rspValid[1]} !== {1'b0, (i == 4)}) begin
                fails++;
                $display("FAIL wait3_cycle_N+%0d: got ready=%b valid=%b, expected ready=0 valid=%b",
                         i, reqReady[1], rspValid[1], (i == 4));
            end
        end
        @(negedge clk);
        tests++;
        if ({reqReady[1], busy[1], rspValid[1]} !== 3'b100) begin
            fails++;
            $display("FAIL wait3_back_to_idle: got ready=%b busy=%b valid=%b, expected 1 0 0",
                     reqReady[1], busy[1], rspValid[1]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic er;
        int lat;
        int n;
        access(1, 1'b1, 3'd2, 32'h28, 32'hCAFEF00D, rd, er, lat);
        @(negedge clk);
        rspReady[1]  = 1'b0;
        reqValid[1]  = 1'b1;
        reqWe[1]     = 1'b0;
        reqFunct3[1] = 3'd2;
        reqAddr[1]   = 32'h28;
        n = 0;
        while (!rspValid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        // req_valid stays high throughout: a second accept would be a bug.
        reqAddr[1] = 32'h10;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({rspValid[1], reqReady[1], rspErr[1], rspRdata[1]} !== {3'b100, 32'hCAFEF00D}) begin
                fails++;
                $display("FAIL backpressure_hold%0d: got valid=%b ready=%b err=%b rdata=%h, expected 1 0 0 cafef00d",
                         i, rspValid[1], reqReady[1], rspErr[1], rspRdata[1]);
            end
            @(negedge clk);
        end
        reqValid[1] = 1'b0;
        rspReady[1] = 1'b1;
        @(negedge clk);
        tests++;
        if ({rspValid[1], reqReady[1], busy[1]} !== 3'b010) begin
            fails++;
            $display("FAIL backpressure_release: got valid=%b ready=%b busy=%b, expected 0 1 0",
                     rspValid[1], reqReady[1], busy[1]);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd;
        logic er;
        int lat;
        @(negedge clk);
        reqValid[1]  = 1'b1;
        reqWe[1]     = 1'b1;
        reqFunct3[1] = 3'd2;
        reqAddr[1]   = 32'h20;
        reqWdata[1]  = 32'h12345678;
        @(posedge clk);
        #1 reqValid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (busy[1] !== 1'b1) begin
            fails++;
            $display("FAIL midop_busy_before_reset: got %b, expected 1", busy[1]);
        end
        rstN[1] = 1'b0;
        #1;
        tests++;
        if ({reqReady[1], rspValid[1], rspErr[1], busy[1], rspRdata[1]} !== {4'b1000, 32'd0}) begin
            fails++;
            $display("FAIL midop_async_reset: got rdy=%b vld=%b err=%b busy=%b rdata=%h, expected 1 0 0 0 00000000",
                     reqReady[1], rspValid[1], rspErr[1], busy[1], rspRdata[1]);
        end
        @(negedge clk);
        rstN[1] = 1'b1;
        access(1, 1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
        tests++;
        if ({er, rd} !== {1'b0, 32'h00000000}) begin
            fails++;
            $display("FAIL midop_store_discarded: got err=%b rdata=%h, expected err=0 rdata=00000000", er, rd);
        end
        access(1, 1'b1, 3'd2, 32'h20, 32'h12345678, rd, er, lat);
        access(1, 1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
        tests++;
        if ({er, rd} !== {1'b0, 32'h12345678}) begin
            fails++;
            $display("FAIL store_without_reset: got err=%b rdata=%h, expected err=0 rdata=12345678", er, rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        for (int d = 0; d < 2; d++) begin
            rstN[d]      = 1'b0;
            reqValid[d]  = 1'b0;
            reqWe[d]     = 1'b0;
            reqFunct3[d] = 3'd0;
            reqAddr[d]   = 32'd0;
            reqWdata[d]  = 32'd0;
            rspReady[d]  = 1'b1;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rstN[0] = 1'b1;
        rstN[1] = 1'b1;
        test_word();
        test_subword();
        test_faults();
        test_wait_latency();
        test_backpressure();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
